// File: rtl/vector_pkg.sv
// Shared definitions for the vector ALU pipeline: operation encodings and the
// operation type used by the lane datapath and the pipeline registers.
package vector_pkg;

    localparam logic [2:0] MOD_ADD  = 3'd0;
    localparam logic [2:0] MOD_SUB  = 3'd1;
    localparam logic [2:0] MOD_AND  = 3'd2;
    localparam logic [2:0] MOD_OR   = 3'd3;
    localparam logic [2:0] MOD_XOR  = 3'd4;
    localparam logic [2:0] MOD_MIN  = 3'd5;
    localparam logic [2:0] MOD_SADD = 3'd6;
    localparam logic [2:0] MOD_SSUB = 3'd7;

    typedef enum logic [2:0] {
        OP_ADD  = MOD_ADD,
        OP_SUB  = MOD_SUB,
        OP_AND  = MOD_AND,
        OP_OR   = MOD_OR,
        OP_XOR  = MOD_XOR,
        OP_MIN  = MOD_MIN,
        OP_SADD = MOD_SADD,
        OP_SSUB = MOD_SSUB
    } op_e;

endpackage

// File: rtl/vector_lane.sv
// One SIMD lane of the vector ALU: purely combinational, no state.
// Saturating add/subtract are built only when VECTOR_ALU_SAT_EN is defined;
// otherwise those encodings fall back to wrapping add/subtract.
module vector_lane
    import vector_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  op_e               op_i,
    output logic [LANE_W-1:0] res_o,
    output logic              ovf_o
);

    logic [LANE_W:0] sumExt;
    logic [LANE_W:0] diffExt;

    // The extra top bit carries the lane's carry-out or borrow.
    assign sumExt  = {1'b0, a_i} + {1'b0, b_i};
    assign diffExt = {1'b0, a_i} - {1'b0, b_i};

    // Select the lane result and its carry/borrow flag for the operation.
    always_comb begin
        res_o = '0;
        ovf_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o = sumExt[LANE_W-1:0];
                ovf_o = sumExt[LANE_W];
            end
            OP_SUB: begin
                res_o = diffExt[LANE_W-1:0];
                ovf_o = diffExt[LANE_W];
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_MIN: res_o = (a_i < b_i) ? a_i : b_i;
`ifdef VECTOR_ALU_SAT_EN
            OP_SADD: begin
                res_o = sumExt[LANE_W] ? '1 : sumExt[LANE_W-1:0];
                ovf_o = sumExt[LANE_W];
            end
            OP_SSUB: begin
                res_o = diffExt[LANE_W] ? '0 : diffExt[LANE_W-1:0];
                ovf_o = diffExt[LANE_W];
            end
`else
            OP_SADD: begin
                res_o = sumExt[LANE_W-1:0];
                ovf_o = sumExt[LANE_W];
            end
            OP_SSUB: begin
                res_o = diffExt[LANE_W-1:0];
                ovf_o = diffExt[LANE_W];
            end
`endif
            default: begin
                res_o = '0;
                ovf_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage SIMD ALU with valid/ready handshakes on both sides.
// Stage 1 holds the operands and operation, stage 2 holds the lane results.
// Optional feature macro: VECTOR_ALU_SAT_EN enables saturating modes 6 and 7.
module vector_alu_pipe
    import vector_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] A,
    input  logic [LANES*LANE_W-1:0] B,
    input  logic [2:0]              mod,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out,
    output logic [LANES-1:0]        ovf
);

    logic                    s1Valid_q, s1Valid_d;
    logic [LANES*LANE_W-1:0] s1A_q, s1A_d;
    logic [LANES*LANE_W-1:0] s1B_q, s1B_d;
    op_e                     s1Op_q, s1Op_d;
    logic                    s2Valid_q, s2Valid_d;
    logic [LANES*LANE_W-1:0] out_q, out_d;
    logic [LANES-1:0]        ovf_q, ovf_d;

    logic                    load1;
    logic                    load2;
    logic [LANES*LANE_W-1:0] laneRes;
    logic [LANES-1:0]        laneOvf;

    // Stage 2 moves whenever it is empty or its beat is being taken; stage 1
    // moves whenever it is empty or stage 2 is about to take its beat.
    assign load2 = !s2Valid_q || out_ready;
    assign load1 = !s1Valid_q || load2;

    assign in_ready  = load1;
    assign out_valid = s2Valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;

    for (genvar i = 0; i < LANES; i++) begin : gLane
        vector_lane #(
            .LANE_W(LANE_W)
        ) uLane (
            .a_i  (s1A_q[i*LANE_W +: LANE_W]),
            .b_i  (s1B_q[i*LANE_W +: LANE_W]),
            .op_i (s1Op_q),
            .res_o(laneRes[i*LANE_W +: LANE_W]),
            .ovf_o(laneOvf[i])
        );
    end

    // Next-state for both stages; data only changes when a real beat moves in.
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Op_d    = s1Op_q;
        s2Valid_d = s2Valid_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        if (load1) begin
            s1Valid_d = in_valid;
            if (in_valid) begin
                s1A_d  = A;
                s1B_d  = B;
                s1Op_d = op_e'(mod);
            end
        end
        if (load2) begin
            s2Valid_d = s1Valid_q;
            if (s1Valid_q) begin
                out_d = laneRes;
                ovf_d = laneOvf;
            end
        end
    end

    // Pipeline registers; reset empties both stages and clears the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Op_q    <= OP_ADD;
            s2Valid_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Op_q    <= s1Op_d;
            s2Valid_q <= s2Valid_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Self-checking bench for vector_alu_pipe (LANES=4, LANE_W=8).
// Expected results come from a behavioural lane model pushed into a queue when
// a beat is accepted and popped when the DUT retires a result.
// Honours VECTOR_ALU_SAT_EN in the model the same way the design does.
module tb_vector_alu_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  mod = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic [3:0]  ovf;

    exp_t        sbQ[$];
    int          assertCount = 0;
    int          failCount = 0;
    int          pushCount = 0;
    int          popCount = 0;
    bit          randReady = 1'b0;
    bit          prevStall = 1'b0;
    logic [31:0] prevOut = '0;
    logic [3:0]  prevOvf = '0;

    vector_alu_pipe #(
        .LANES (4),
        .LANE_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .mod      (mod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .ovf      (ovf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count one comparison and report it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Behavioural model of all lanes for one beat
    function automatic exp_t modelCalc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        exp_t e;
        int   x;
        int   y;
        int   s;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'(a[i*8 +: 8]);
            y = int'(b[i*8 +: 8]);
            case (m)
                3'd0: begin s = x + y; e.res[i*8 +: 8] = 8'(s); e.ovf[i] = (s > 255); end
                3'd1: begin s = x - y; e.res[i*8 +: 8] = 8'(s); e.ovf[i] = (x < y); end
                3'd2: e.res[i*8 +: 8] = 8'(x & y);
                3'd3: e.res[i*8 +: 8] = 8'(x | y);
                3'd4: e.res[i*8 +: 8] = 8'(x ^ y);
                3'd5: e.res[i*8 +: 8] = 8'((x < y) ? x : y);
                3'd6: begin
                    s = x + y;
                    e.ovf[i] = (s > 255);
`ifdef VECTOR_ALU_SAT_EN
                    e.res[i*8 +: 8] = (s > 255) ? 8'hff : 8'(s);
`else
                    e.res[i*8 +: 8] = 8'(s);
`endif
                end
                default: begin
                    s = x - y;
                    e.ovf[i] = (x < y);
`ifdef VECTOR_ALU_SAT_EN
                    e.res[i*8 +: 8] = (x < y) ? 8'h00 : 8'(s);
`else
                    e.res[i*8 +: 8] = 8'(s);
`endif
                end
            endcase
        end
        return e;
    endfunction

    // Scoreboard monitor sampling on the falling edge, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prevStall) begin
                checkOutput("stall out stable", out, prevOut);
                checkOutput("stall ovf stable", {28'b0, ovf}, {28'b0, prevOvf});
            end
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("spurious beat", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    popCount++;
                    checkOutput("sb out", out, e.res);
                    checkOutput("sb ovf", {28'b0, ovf}, {28'b0, e.ovf});
                end
            end
            if (in_valid && in_ready) begin
                sbQ.push_back(modelCalc(A, B, mod));
                pushCount++;
            end
            prevStall = out_valid && !out_ready;
            prevOut   = out;
            prevOvf   = ovf;
        end else begin
            prevStall = 1'b0;
        end
    end

    // Pseudo-random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one beat and hold it until accepted (bounded)
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        bit accepted;
        int waitCycles;
        accepted   = 1'b0;
        waitCycles = 0;
        A = a;
        B = b;
        mod = m;
        in_valid = 1'b1;
        while (!accepted && waitCycles < 200) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (!accepted) checkOutput("accept timeout", {31'b0, accepted}, 32'd1);
        in_valid = 1'b0;
    endtask

    // Let every outstanding beat retire (bounded)
    task automatic drainPipe();
        int n;
        n = 0;
        randReady = 1'b0;
        out_ready = 1'b1;
        while (sbQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain empty", sbQ.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Single beat on an empty pipe: latency plus fixed expected result
    task automatic runDirected(input string tag, input logic [2:0] m, input logic [31:0] expOut, input logic [3:0] expOvf);
        int lat;
        A = 32'h0000ffff;
        B = 32'h0abcffff;
        mod = m;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, lat, 32'd2);
        checkOutput({tag, " out"}, out, expOut);
        checkOutput({tag, " ovf"}, {28'b0, ovf}, {28'b0, expOvf});
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int popBefore;
        logic [31:0] edgeA[4];
        logic [31:0] edgeB[4];

        $display("[TB] starting vector_alu_pipe bench");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset out", out, 32'd0);
        checkOutput("reset ovf", {28'b0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        runDirected("add", 3'd0, 32'h0abcfefe, 4'b0011);
        runDirected("sub", 3'd1, 32'hf6440000, 4'b1100);
        runDirected("min", 3'd5, 32'h0000ffff, 4'b0000);
`ifdef VECTOR_ALU_SAT_EN
        runDirected("sadd", 3'd6, 32'h0abcffff, 4'b0011);
`else
        runDirected("sadd", 3'd6, 32'h0abcfefe, 4'b0011);
`endif

        // Every mode with boundary operands, back to back
        edgeA[0] = 32'hffffffff; edgeB[0] = 32'h01010101;
        edgeA[1] = 32'h00000000; edgeB[1] = 32'h01ff80ff;
        edgeA[2] = 32'h807f00ff; edgeB[2] = 32'h7f80ff00;
        edgeA[3] = 32'h12345678; edgeB[3] = 32'h12345678;
        for (int m = 0; m < 8; m++) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus(edgeA[k], edgeB[k], 3'(m));
            end
        end
        drainPipe();

        // Backpressure: with out_ready low only two beats fit
        out_ready = 1'b0;
        A = 32'hdeadbeef;
        B = 32'h0f0f0f0f;
        mod = 3'd4;
        in_valid = 1'b1;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        checkOutput("stall accepted", acc, 32'd2);
        @(negedge clk);
        checkOutput("stall in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drainPipe();

        // Random stream with random backpressure
        popBefore = popCount;
        randReady = 1'b1;
        for (int n = 0; n < 16; n++) begin
            applyStimulus($urandom, $urandom, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drainPipe();
        checkOutput("stream count", popCount - popBefore, 32'd16);

        // Reset with both stages full
        out_ready = 1'b0;
        applyStimulus(32'h11223344, 32'h55667788, 3'd0);
        applyStimulus(32'h99aabbcc, 32'h01020304, 3'd1);
        @(negedge clk);
        checkOutput("full out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid reset out", out, 32'd0);
        checkOutput("mid reset ovf", {28'b0, ovf}, 32'd0);
        sbQ.delete();
        prevStall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("release out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Pipe still works after the mid-flight reset
        runDirected("post-reset add", 3'd0, 32'h0abcfefe, 4'b0011);
        drainPipe();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vector_alu_pipe.md
VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent SIMD lanes.
REQ-002 SHALL have parameter LANE_W, default 8, bit width of each lane; total operand width is LANES*LANE_W.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port A  input  LANES*LANE_W  operand A; lane i occupies bits [i*LANE_W +: LANE_W].
REQ-008 SHALL have port B  input  LANES*LANE_W  operand B, same lane packing as A.
REQ-009 SHALL have port mod  input  3  operation select, sampled with the beat.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out  output  LANES*LANE_W  per-lane result.
REQ-013 SHALL have port ovf  output  LANES  per-lane carry/borrow flag, qualified by out_valid.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready; SHALL present a result when out_valid && out_ready.
REQ-015 SHALL decode mod: 0 ADD wrap, 1 SUB wrap (A-B), 2 AND, 3 OR, 4 XOR, 5 MIN unsigned, 6 SADD, 7 SSUB.
REQ-016 SHALL compute every lane independently; no carry or borrow crosses a lane boundary.
REQ-017 SHALL set ovf[i] on unsigned carry-out (ADD/SADD) or borrow (SUB/SSUB); 0 for modes 2-5.
REQ-018 SHALL clamp SADD to all-ones and SSUB to zero on overflow of that lane.
REQ-019 SHALL be a two-stage pipeline: S1 registers A, B, mod; S2 registers out, ovf.
REQ-020 SHALL have latency of exactly 2 cycles from acceptance to out_valid while out_ready is held high.
REQ-021 SHALL sustain one beat per cycle with out_ready high.
REQ-022 SHALL load S2 when !S2_valid || out_ready; SHALL load S1 when !S1_valid || S2 loads.
REQ-023 SHALL drive in_ready = !S1_valid || S2-load-enable; in_ready SHALL NOT depend on in_valid.
REQ-024 SHALL hold out and ovf stable while out_valid && !out_ready.
REQ-025 SHALL drop no beat, duplicate no beat and reorder no beat under any out_ready pattern.
REQ-026 SHALL accept and retire a beat in the same cycle when both stages are full and out_ready is high.

Reset
REQ-027 SHALL, on rst_n low, clear S1_valid and S2_valid and set out=0, ovf=0, out_valid=0 asynchronously.
REQ-028 SHALL discard in-flight beats on reset mid-operation; in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL compile modes 6 and 7 only when macro VECTOR_ALU_SAT_EN is defined.
REQ-030 SHALL, without VECTOR_ALU_SAT_EN, treat mod 6 as ADD and mod 7 as SUB (wrap, ovf still reported).

Structure
REQ-031 SHALL place the mod encodings as named constants and the op typedef in shared package vector_pkg.
REQ-032 SHALL implement one lane's combinational datapath in sub-module vector_lane, generated LANES times.

Verification (LANES=4, LANE_W=8, A=32'h0000ffff, B=32'h0abcffff)
REQ-033 SHALL check mod=0 -> out=32'h0abcfefe, ovf=4'b0011, out_valid exactly 2 cycles after acceptance.
REQ-034 SHALL check mod=1 -> out=32'hf6440000, ovf=4'b1100; mod=5 -> out=32'h0000ffff, ovf=0.
REQ-035 SHALL check mod=6 with VECTOR_ALU_SAT_EN -> out=32'h0abcffff, ovf=4'b0011; without it -> 32'h0abcfefe.
REQ-036 SHALL stream 16 beats with out_ready toggled pseudo-randomly and compare in order against a model: no loss, no duplicate, out stable while stalled.
REQ-037 SHALL hold out_ready low for 4 cycles with in_valid high -> exactly 2 beats accepted, then in_ready=0.
REQ-038 SHALL assert rst_n low with both stages full -> out_valid=0 and out=0 immediately; in_ready=1 after release.
